// File: rtl/auction_seq_ctrl.sv
// auction_seq_ctrl
// Sequential sealed-bid auction over 2**N bidders using one W-bit comparator.
// Bids arrive serially in index order 0..2**N-1. The block keeps the running
// highest bid and its owner's index. It then presents winner/highest with a
// valid/ack handshake. On equal bids the lower index wins.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         begin an auction (IDLE, or DONE together with result_ack)
//   bid_valid/bid serial bid input, qualified by bid_ready
//   bid_ready     high in COLLECT
//   bid_idx       index of the bidder expected next
//   busy          high in COLLECT and DONE
//   result_valid  high in DONE; winner/highest are valid
//   result_ack    consumer has taken the result
//   winner        index of the highest bidder
//   highest       winning bid value
module auction_seq_ctrl #(
    parameter int N = 2,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         bid_valid,
    input  logic [W-1:0] bid,
    output logic         bid_ready,
    output logic [N-1:0] bid_idx,
    output logic         busy,
    output logic         result_valid,
    input  logic         result_ack,
    output logic [N-1:0] winner,
    output logic [W-1:0] highest
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t       state, state_nx;
    logic [N-1:0] cnt;
    logic         beat;
    logic         last;
    logic         clr_cnt;

    // The N-bit counter wraps to 0 on the final beat. That is harmless: the
    // FSM is in DONE by then, and the counter is cleared again on start.
    assign last = &cnt;
    assign beat = bid_valid && (state == COLLECT);

    always_comb begin
        state_nx = state;
        clr_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = COLLECT;
                    clr_cnt  = 1'b1;
                end
            end
            COLLECT: begin
                if (beat && last) state_nx = DONE;
            end
            DONE: begin
                if (result_ack) begin
                    if (start) begin
                        state_nx = COLLECT;
                        clr_cnt  = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            winner  <= '0;
            highest <= '0;
        end else begin
            state <= state_nx;
            if (clr_cnt) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
                // The first beat loads unconditionally so no stale value from
                // a previous auction can win. Later beats use a strict compare,
                // so on a tie the earlier, lower index is kept.
                if (cnt == '0) begin
                    highest <= bid;
                    winner  <= '0;
                end else if (bid > highest) begin
                    highest <= bid;
                    winner  <= cnt;
                end
            end
        end
    end

    assign bid_ready    = (state == COLLECT);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign bid_idx      = cnt;

endmodule

// File: tb/tb_auction_seq_ctrl.sv
module tb_auction_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: N=2, W=8
    logic       start_a, bv_a, ack_a;
    logic [7:0] bid_a;
    logic       br_a, busy_a, rv_a;
    logic [1:0] idx_a, win_a;
    logic [7:0] hi_a;

    // DUT B: N=1, W=4
    logic       start_b, bv_b, ack_b;
    logic [3:0] bid_b;
    logic       br_b, busy_b, rv_b;
    logic [0:0] idx_b, win_b;
    logic [3:0] hi_b;

    auction_seq_ctrl #(.N(2), .W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bid_valid(bv_a), .bid(bid_a),
        .bid_ready(br_a), .bid_idx(idx_a), .busy(busy_a), .result_valid(rv_a),
        .result_ack(ack_a), .winner(win_a), .highest(hi_a)
    );

    auction_seq_ctrl #(.N(1), .W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bid_valid(bv_b), .bid(bid_b),
        .bid_ready(br_b), .bid_idx(idx_b), .busy(busy_b), .result_valid(rv_b),
        .result_ack(ack_b), .winner(win_b), .highest(hi_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int win;
        int hi;
    } res_t;

    res_t q_a[$];
    res_t q_b[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitors: pop one expected result on each rising result_valid and
    // check it on every cycle that result_valid stays high.
    logic prv_a = 1'b0;
    logic prv_b = 1'b0;
    res_t cur_a, cur_b;

    always @(negedge clk) begin
        if (rv_a) begin
            if (!prv_a) begin
                if (q_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result_a: got winner %0d highest %0d with empty queue", win_a, hi_a);
                    cur_a = '{-1, -1};
                end else begin
                    cur_a = q_a.pop_front();
                end
            end
            chk("winner_a", 32'(win_a), cur_a.win);
            chk("highest_a", 32'(hi_a), cur_a.hi);
        end
        prv_a = rv_a;
    end

    always @(negedge clk) begin
        if (rv_b) begin
            if (!prv_b) begin
                if (q_b.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result_b: got winner %0d highest %0d with empty queue", win_b, hi_b);
                    cur_b = '{-1, -1};
                end else begin
                    cur_b = q_b.pop_front();
                end
            end
            chk("winner_b", 32'(win_b), cur_b.win);
            chk("highest_b", 32'(hi_b), cur_b.hi);
        end
        prv_b = rv_b;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DUT A helpers ----------------
    task automatic start_pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start_ready_a", 32'(br_a), 1);
        chk("start_idx_a", 32'(idx_a), 0);
        chk("start_busy_a", 32'(busy_a), 1);
    endtask

    task automatic beat_a(input int v, input int idx);
        bv_a  = 1'b1;
        bid_a = 8'(v);
        chk("bid_idx_a", 32'(idx_a), idx);
        chk("bid_ready_a", 32'(br_a), 1);
        tick();
        bv_a = 1'b0;
    endtask

    // Bubble cycles, optionally poking start and result_ack, which
    // must both be ignored in COLLECT.
    task automatic bubbles_a(input int n, input bit poke, input int idx);
        repeat (n) begin
            if (poke) begin
                start_a = 1'b1;
                ack_a   = 1'b1;
            end
            tick();
            start_a = 1'b0;
            ack_a   = 1'b0;
            chk("bubble_idx_a", 32'(idx_a), idx);
            chk("bubble_rv_a", 32'(rv_a), 0);
        end
    endtask

    task automatic auction_a(input int b[4], input int ew, input int eh,
                             input bit gaps, input bit poke);
        q_a.push_back('{ew, eh});
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && gaps)
                bubbles_a(poke ? $urandom_range(3, 1) : $urandom_range(3, 0), poke, i);
            beat_a(b[i], i);
        end
        chk("latency_rv_a", 32'(rv_a), 1);
        chk("done_ready_a", 32'(br_a), 0);
        chk("done_busy_a", 32'(busy_a), 1);
    endtask

    task automatic ack_pulse_a(input bit with_start);
        ack_a   = 1'b1;
        start_a = with_start;
        tick();
        ack_a   = 1'b0;
        start_a = 1'b0;
        chk("ack_rv_a", 32'(rv_a), 0);
        chk("ack_busy_a", 32'(busy_a), with_start ? 1 : 0);
        chk("ack_ready_a", 32'(br_a), with_start ? 1 : 0);
        if (with_start) chk("b2b_idx_a", 32'(idx_a), 0);
    endtask

    // ---------------- DUT B helpers ----------------
    task automatic beat_b(input int v, input int idx);
        bv_b  = 1'b1;
        bid_b = 4'(v);
        chk("bid_idx_b", 32'(idx_b), idx);
        chk("bid_ready_b", 32'(br_b), 1);
        tick();
        bv_b = 1'b0;
    endtask

    task automatic auction_b(input int b[2], input int ew, input int eh);
        q_b.push_back('{ew, eh});
        for (int i = 0; i < 2; i++) beat_b(b[i], i);
        chk("latency_rv_b", 32'(rv_b), 1);
    endtask

    task automatic ack_pulse_b(input bit with_start);
        ack_b   = 1'b1;
        start_b = with_start;
        tick();
        ack_b   = 1'b0;
        start_b = 1'b0;
        chk("ack_rv_b", 32'(rv_b), 0);
        chk("ack_busy_b", 32'(busy_b), with_start ? 1 : 0);
        if (with_start) chk("b2b_idx_b", 32'(idx_b), 0);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_ready"},   32'(br_a),   0);
        chk({tag, "_busy"},    32'(busy_a), 0);
        chk({tag, "_rv"},      32'(rv_a),   0);
        chk({tag, "_idx"},     32'(idx_a),  0);
        chk({tag, "_winner"},  32'(win_a),  0);
        chk({tag, "_highest"}, 32'(hi_a),   0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 0; bv_a = 0; ack_a = 0; bid_a = '0;
        start_b = 0; bv_b = 0; ack_b = 0; bid_b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_zero_a("reset_a");
        chk("reset_busy_b", 32'(busy_b), 0);
        chk("reset_rv_b", 32'(rv_b), 0);
        chk("reset_winner_b", 32'(win_b), 0);
        chk("reset_highest_b", 32'(hi_b), 0);

        // bid_valid and result_ack in IDLE are ignored
        bv_a = 1'b1; bid_a = 8'd77; ack_a = 1'b1;
        tick();
        bv_a = 1'b0; ack_a = 1'b0;
        chk_zero_a("idle_ign_a");

        // Tie between bidders 1 and 2 resolves to 1
        start_pulse_a();
        auction_a('{3, 9, 9, 1}, 1, 9, 0, 0);
        ack_pulse_a(0);

        start_pulse_a();
        auction_a('{0, 0, 0, 0}, 0, 0, 0, 0);
        ack_pulse_a(1);
        auction_a('{1, 2, 3, 255}, 3, 255, 0, 0);
        ack_pulse_a(1);
        auction_a('{200, 100, 50, 0}, 0, 200, 0, 0);
        ack_pulse_a(0);

        // Bubbles with start/ack pokes mid-collect; then withhold ack
        start_pulse_a();
        auction_a('{5, 7, 6, 7}, 1, 7, 1, 1);
        start_a = 1'b1;
        repeat (10) begin
            tick();
            chk("hold_rv_a", 32'(rv_a), 1);
        end
        start_a = 1'b0;
        ack_pulse_a(0);

        // Reset mid-auction, asserted together with start
        start_pulse_a();
        beat_a(50, 0);
        beat_a(60, 1);
        rst = 1'b1; start_a = 1'b1;
        tick();
        rst = 1'b0; start_a = 1'b0;
        chk_zero_a("midrst_a");
        start_pulse_a();
        auction_a('{1, 1, 1, 2}, 3, 2, 0, 0);
        ack_pulse_a(1);
        auction_a('{4, 4, 4, 4}, 0, 4, 0, 0);
        ack_pulse_a(0);

        // N=1 instance: terminal detection on a single-bit counter
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("start_ready_b", 32'(br_b), 1);
        auction_b('{15, 15}, 0, 15);
        ack_pulse_b(1);
        auction_b('{3, 15}, 1, 15);
        ack_pulse_b(0);

        tick();
        tick();
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

endmodule

// File: doc/auction_seq_ctrl.md
Name: auction_seq_ctrl

Overview:
Sequential controller that runs one sealed-bid auction over 2**N bidders, using a single W-bit comparator instead of the combinational comparator tree. Bids arrive serially, one bidder per accepted beat, in index order 0..2**N-1. The block keeps the running highest bid and the index of its owner, then presents winner/highest to the consumer with a valid/ack handshake. Its tie rule matches the combinational tournament: on equal bids, the lower index wins.

Parameters:
N, 2, log2 of bidder count (2**N bidders, N >= 1)
W, 8, bid width in bits (unsigned)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse: begin a new auction; honoured only in IDLE or together with result_ack in DONE
bid_valid  input  1  bid holds a valid bid for bidder bid_idx
bid  input  W  unsigned bid value
bid_ready  output  1  controller accepts a bid this cycle
bid_idx  output  N  index of the bidder whose bid is expected next
busy  output  1  high in COLLECT and DONE
result_valid  output  1  winner/highest are valid
result_ack  input  1  consumer has taken the result
winner  output  N  index of the highest bidder
highest  output  W  winning bid value

Behaviour:
- Reset (rst=1 at clk edge, from any state, including mid-auction): state=IDLE; bid_ready=0, busy=0, result_valid=0, bid_idx=0, winner=0, highest=0. Any partial auction is discarded.
- States: IDLE, COLLECT, DONE. All outputs are registered or decoded from state only. No combinational path from inputs to outputs.
- IDLE:
  - bid_ready=0, busy=0.
  - start=1 -> COLLECT next cycle with cnt=0, bid_idx=0.
  - bid_valid is ignored.
- COLLECT:
  - bid_ready=1, busy=1.
  - Beat = bid_valid & bid_ready. With bid_valid=0, nothing changes, so any number of bubble cycles is allowed.
  - Beat with cnt==0: load highest<=bid and winner<=0 unconditionally.
  - Beat with cnt>0: if bid > highest (strict, unsigned), then highest<=bid and winner<=cnt. Otherwise both hold, so ties keep the earlier, lower index.
  - Each beat increments cnt; bid_idx tracks cnt.
  - Beat with cnt==2**N-1: go to DONE next cycle. cnt does not wrap into another collection.
  - start is ignored in COLLECT.
- DONE:
  - result_valid=1, bid_ready=0, busy=1.
  - winner and highest are held stable until acknowledged.
  - result_ack=1 with start=0 -> IDLE next cycle.
  - result_ack=1 with start=1 -> COLLECT next cycle (back-to-back auction), cnt=0, result_valid drops.
  - start without result_ack is ignored. result_ack outside DONE is ignored.
- Latency:
  - result_valid rises on the cycle after the last beat.
  - Minimum auction is 1 cycle (start) + 2**N beat cycles + 1 cycle to result_valid.
- winner/highest during COLLECT show the running values and are not qualified. Consumers read them only while result_valid=1.
- Simultaneous rst with any other input: reset wins.
- Widths:
  - cnt is N+1 bits internally, or N bits with an explicit last-beat decode; terminal detection must be correct for N=1.
  - The comparison is a full W-bit unsigned compare with no truncation.

Test Plan:
- N=2, W=8, bids 3,9,9,1 on consecutive beats -> result_valid one cycle after 4th beat; winner=1, highest=9 (tie with bidder 2 resolved to lower index).
- Bids 0,0,0,0 -> winner=0, highest=0. Bids 1,2,3,255 -> winner=3, highest=255. Bids 200,100,50,0 -> winner=0, highest=200.
- Bids 5,7,6,7 with bid_valid low 0-3 random cycles between beats -> bid_idx steps 0,1,2,3 only on beats; winner=1, highest=7; result unchanged by bubbles.
- start pulsed mid-COLLECT, and result_ack pulsed mid-COLLECT -> no effect; result_ack withheld 10 cycles in DONE -> result_valid, winner and highest stay constant; then ack -> IDLE, busy=0.
- rst asserted after 2 beats (bids 50,60) -> next cycle all outputs 0, state IDLE; new start with bids 1,1,1,2 -> winner=3, highest=2 (no residue of 60).
- result_ack and start in the same cycle in DONE -> COLLECT next cycle with bid_idx=0 and bid_ready=1; second auction 4,4,4,4 -> winner=0, highest=4. Repeat with N=1, W=4: bids 15,15 -> winner=0; bids 3,15 -> winner=1.
